// File: rtl/axi_arb_req_buffer_if.sv
// Request stream bundle around the arbitration request buffer: the tree-side
// request/grant pair, the slave-side request/grant pair and occupancy status.
interface axi_arb_req_buffer_if #(
   parameter int unsigned AUX_WIDTH = 64,
   parameter int unsigned ID_WIDTH  = 20,
   parameter int unsigned DEPTH     = 4
);
   localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1);

   logic                 data_req_i;
   logic [AUX_WIDTH-1:0] data_AUX_i;
   logic [ID_WIDTH-1:0]  data_ID_i;
   logic                 data_gnt_o;
   logic                 data_req_o;
   logic [AUX_WIDTH-1:0] data_AUX_o;
   logic [ID_WIDTH-1:0]  data_ID_o;
   logic                 data_gnt_i;
   logic                 full_o;
   logic                 empty_o;
   logic [CNT_WIDTH-1:0] count_o;

   // Buffer view
   modport slave (
      input  data_req_i, data_AUX_i, data_ID_i, data_gnt_i,
      output data_gnt_o, data_req_o, data_AUX_o, data_ID_o, full_o, empty_o, count_o
   );

   // Environment view (tree + slave-side port)
   modport master (
      output data_req_i, data_AUX_i, data_ID_i, data_gnt_i,
      input  data_gnt_o, data_req_o, data_AUX_o, data_ID_o, full_o, empty_o, count_o
   );
endinterface

// File: rtl/axi_arb_req_buffer.sv
// Elastic DEPTH-entry FIFO behind the request arbitration tree. The grant back
// to the tree depends only on occupancy, cutting the combinational gnt path
// from the slave port through the tree. No bypass: data appears one cycle
// after push at the earliest. Order is strictly preserved.
module axi_arb_req_buffer #(
   parameter int unsigned AUX_WIDTH = 64,
   parameter int unsigned ID_WIDTH  = 20,
   parameter int unsigned DEPTH     = 4
) (
   input logic                 clk,
   input logic                 rst,
   axi_arb_req_buffer_if.slave bus
);
   localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1);
   localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
   localparam int unsigned ENT_WIDTH = AUX_WIDTH + ID_WIDTH;

   logic [ENT_WIDTH-1:0] mem_q [DEPTH];
   logic [ENT_WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic                 full, empty, push, pop;

   // full/empty come from the count only; pointers wrap naturally
   assign full  = (count_q == CNT_WIDTH'(DEPTH));
   assign empty = (count_q == '0);
   assign push  = bus.data_req_i & ~full;
   assign pop   = bus.data_gnt_i & ~empty;

   assign bus.data_gnt_o = ~full;
   assign bus.data_req_o = ~empty;
   assign bus.full_o     = full;
   assign bus.empty_o    = empty;
   assign bus.count_o    = count_q;
   assign {bus.data_AUX_o, bus.data_ID_o} = mem_q[rd_ptr_q];

   // Next-state: write at tail on push, advance head on pop, track occupancy
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = {bus.data_AUX_i, bus.data_ID_i};
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // State registers; reset clears storage so head outputs read zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

   a_count_range: assert property (@(posedge clk) disable iff (rst)
      count_q <= CNT_WIDTH'(DEPTH));
   a_no_push_full: assert property (@(posedge clk) disable iff (rst)
      !(bus.data_req_i && bus.data_gnt_o && full));
   a_head_stable: assert property (@(posedge clk) disable iff (rst)
      (bus.data_req_o && !bus.data_gnt_i) |=> ($stable(bus.data_AUX_o) && $stable(bus.data_ID_o)));
endmodule

// File: tb/tb_axi_arb_req_buffer.sv
// Directed and scoreboarded bench for the arbitration request buffer
// (DEPTH 4 for directed scenarios, DEPTH 2 and 8 for random traffic).
module tb_axi_arb_req_buffer;
   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   axi_arb_req_buffer_if #(.AUX_WIDTH(64), .ID_WIDTH(20), .DEPTH(4)) b4 ();
   axi_arb_req_buffer_if #(.AUX_WIDTH(64), .ID_WIDTH(20), .DEPTH(2)) b2 ();
   axi_arb_req_buffer_if #(.AUX_WIDTH(64), .ID_WIDTH(20), .DEPTH(8)) b8 ();

   axi_arb_req_buffer #(.AUX_WIDTH(64), .ID_WIDTH(20), .DEPTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
   axi_arb_req_buffer #(.AUX_WIDTH(64), .ID_WIDTH(20), .DEPTH(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
   axi_arb_req_buffer #(.AUX_WIDTH(64), .ID_WIDTH(20), .DEPTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      b4.data_req_i = 1'b0; b4.data_AUX_i = '0; b4.data_ID_i = '0; b4.data_gnt_i = 1'b0;
      b2.data_req_i = 1'b0; b2.data_AUX_i = '0; b2.data_ID_i = '0; b2.data_gnt_i = 1'b0;
      b8.data_req_i = 1'b0; b8.data_AUX_i = '0; b8.data_ID_i = '0; b8.data_gnt_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_all();
      step();
      step();
      checks++; if (b4.data_req_o !== 1'b0) begin errors++; $display("FAIL reset_req_o: got %b want 0", b4.data_req_o); end
      checks++; if (b4.data_gnt_o !== 1'b1) begin errors++; $display("FAIL reset_gnt_o: got %b want 1", b4.data_gnt_o); end
      checks++; if (b4.full_o !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", b4.full_o); end
      checks++; if (b4.empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", b4.empty_o); end
      checks++; if (b4.count_o !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", b4.count_o); end
      checks++; if (b4.data_AUX_o !== 64'h0) begin errors++; $display("FAIL reset_aux: got %h want 0", b4.data_AUX_o); end
      checks++; if (b4.data_ID_o !== 20'h0) begin errors++; $display("FAIL reset_id: got %h want 0", b4.data_ID_o); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_single_pass();
      b4.data_req_i = 1'b1; b4.data_AUX_i = 64'h11; b4.data_ID_i = 20'h5; b4.data_gnt_i = 1'b1;
      #1;
      checks++; if (b4.data_req_o !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %b want 0", b4.data_req_o); end
      checks++; if (b4.data_gnt_o !== 1'b1) begin errors++; $display("FAIL single_gnt: got %b want 1", b4.data_gnt_o); end
      step();
      b4.data_req_i = 1'b0;
      checks++; if (b4.data_req_o !== 1'b1) begin errors++; $display("FAIL single_req_o: got %b want 1", b4.data_req_o); end
      checks++; if (b4.data_AUX_o !== 64'h11) begin errors++; $display("FAIL single_aux: got %h want 11", b4.data_AUX_o); end
      checks++; if (b4.data_ID_o !== 20'h5) begin errors++; $display("FAIL single_id: got %h want 5", b4.data_ID_o); end
      checks++; if (b4.count_o !== 3'd1) begin errors++; $display("FAIL single_count: got %0d want 1", b4.count_o); end
      step();
      checks++; if (b4.empty_o !== 1'b1) begin errors++; $display("FAIL single_empty: got %b want 1", b4.empty_o); end
      checks++; if (b4.data_req_o !== 1'b0) begin errors++; $display("FAIL single_req_after: got %b want 0", b4.data_req_o); end
      b4.data_gnt_i = 1'b0;
   endtask

   task automatic test_fill();
      logic pushed;
      b4.data_gnt_i = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         b4.data_req_i = 1'b1; b4.data_ID_i = 20'(i); b4.data_AUX_i = 64'(i);
         step();
      end
      b4.data_ID_i = 20'h5; b4.data_AUX_i = 64'h5;
      checks++; if (b4.full_o !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", b4.full_o); end
      checks++; if (b4.data_gnt_o !== 1'b0) begin errors++; $display("FAIL fill_gnt: got %b want 0", b4.data_gnt_o); end
      checks++; if (b4.count_o !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d want 4", b4.count_o); end
      repeat (3) step();
      checks++; if (b4.count_o !== 3'd4) begin errors++; $display("FAIL fill_held_count: got %0d want 4", b4.count_o); end
      b4.data_gnt_i = 1'b1;
      #1;
      checks++; if (b4.data_gnt_o !== 1'b0) begin errors++; $display("FAIL fill_gnt_indep: got %b want 0", b4.data_gnt_o); end
      for (int k = 0; k < 5; k++) begin
         checks++; if (b4.data_req_o !== 1'b1) begin errors++; $display("FAIL fill_drain_req%0d: got %b want 1", k, b4.data_req_o); end
         checks++; if (b4.data_ID_o !== 20'(k + 1)) begin errors++; $display("FAIL fill_order%0d: got %h want %h", k, b4.data_ID_o, 20'(k + 1)); end
         if (k == 1) begin
            checks++; if (b4.data_gnt_o !== 1'b1) begin errors++; $display("FAIL fill_regrant: got %b want 1", b4.data_gnt_o); end
         end
         pushed = b4.data_req_i && b4.data_gnt_o;
         step();
         if (pushed) b4.data_req_i = 1'b0;
      end
      checks++; if (b4.empty_o !== 1'b1) begin errors++; $display("FAIL fill_empty: got %b want 1", b4.empty_o); end
      b4.data_gnt_i = 1'b0;
   endtask

   task automatic test_stall();
      logic pushed;
      int   nid;
      b4.data_gnt_i = 1'b0;
      b4.data_req_i = 1'b1; b4.data_ID_i = 20'h7; b4.data_AUX_i = 64'h77;
      step();
      nid = 8;
      for (int c = 0; c < 10; c++) begin
         b4.data_ID_i = 20'(nid); b4.data_AUX_i = 64'(nid);
         checks++; if (b4.data_ID_o !== 20'h7) begin errors++; $display("FAIL stall_id%0d: got %h want 7", c, b4.data_ID_o); end
         checks++; if (b4.data_AUX_o !== 64'h77) begin errors++; $display("FAIL stall_aux%0d: got %h want 77", c, b4.data_AUX_o); end
         pushed = b4.data_gnt_o;
         step();
         if (pushed) nid++;
      end
      checks++; if (b4.count_o !== 3'd4) begin errors++; $display("FAIL stall_count: got %0d want 4", b4.count_o); end
      b4.data_req_i = 1'b0; b4.data_gnt_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         checks++; if (b4.data_ID_o !== 20'(7 + k)) begin errors++; $display("FAIL stall_drain%0d: got %h want %h", k, b4.data_ID_o, 20'(7 + k)); end
         step();
      end
      checks++; if (b4.empty_o !== 1'b1) begin errors++; $display("FAIL stall_empty: got %b want 1", b4.empty_o); end
      b4.data_gnt_i = 1'b0;
   endtask

   task automatic test_back_to_back();
      b4.data_gnt_i = 1'b0; b4.data_req_i = 1'b1;
      b4.data_ID_i = 20'h100; b4.data_AUX_i = 64'h100;
      step();
      b4.data_ID_i = 20'h101; b4.data_AUX_i = 64'h101;
      step();
      checks++; if (b4.count_o !== 3'd2) begin errors++; $display("FAIL b2b_prefill: got %0d want 2", b4.count_o); end
      b4.data_gnt_i = 1'b1;
      for (int c = 0; c < 20; c++) begin
         b4.data_ID_i = 20'(32'h102 + c); b4.data_AUX_i = 64'(32'h102 + c);
         checks++; if (b4.data_ID_o !== 20'(32'h100 + c)) begin errors++; $display("FAIL b2b_head%0d: got %h want %h", c, b4.data_ID_o, 20'(32'h100 + c)); end
         step();
         checks++; if (b4.count_o !== 3'd2) begin errors++; $display("FAIL b2b_count%0d: got %0d want 2", c, b4.count_o); end
      end
      b4.data_req_i = 1'b0;
      for (int k = 0; k < 2; k++) begin
         checks++; if (b4.data_ID_o !== 20'(32'h114 + k)) begin errors++; $display("FAIL b2b_tail%0d: got %h want %h", k, b4.data_ID_o, 20'(32'h114 + k)); end
         step();
      end
      checks++; if (b4.empty_o !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b want 1", b4.empty_o); end
      b4.data_gnt_i = 1'b0;
   endtask

   task automatic test_reset_mid();
      b4.data_gnt_i = 1'b0; b4.data_req_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         b4.data_ID_i = 20'(32'hA + i); b4.data_AUX_i = 64'(32'hA + i);
         step();
      end
      b4.data_req_i = 1'b0;
      checks++; if (b4.count_o !== 3'd3) begin errors++; $display("FAIL rmid_pre_count: got %0d want 3", b4.count_o); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (b4.data_req_o !== 1'b0) begin errors++; $display("FAIL rmid_req: got %b want 0", b4.data_req_o); end
      checks++; if (b4.count_o !== 3'd0) begin errors++; $display("FAIL rmid_count: got %0d want 0", b4.count_o); end
      checks++; if (b4.data_gnt_o !== 1'b1) begin errors++; $display("FAIL rmid_gnt: got %b want 1", b4.data_gnt_o); end
      checks++; if (b4.empty_o !== 1'b1) begin errors++; $display("FAIL rmid_empty: got %b want 1", b4.empty_o); end
      checks++; if (b4.data_ID_o !== 20'h0) begin errors++; $display("FAIL rmid_id: got %h want 0", b4.data_ID_o); end
      step();
      rst = 1'b0;
      step();
      checks++; if (b4.count_o !== 3'd0) begin errors++; $display("FAIL rmid_post_count: got %0d want 0", b4.count_o); end
   endtask

   task automatic test_random_d2();
      logic [83:0] q[$];
      logic [83:0] pend;
      logic        holding;
      int unsigned cnt;
      holding = 1'b0; pend = '0;
      for (int n = 0; n < 1000; n++) begin
         cnt = q.size();
         checks++; if (b2.count_o !== 2'(cnt)) begin errors++; $display("FAIL rnd2_count@%0d: got %0d want %0d", n, b2.count_o, cnt); end
         checks++; if (b2.data_gnt_o !== (cnt != 2)) begin errors++; $display("FAIL rnd2_gnt@%0d: got %b want %b", n, b2.data_gnt_o, cnt != 2); end
         checks++; if (b2.data_req_o !== (cnt != 0)) begin errors++; $display("FAIL rnd2_req@%0d: got %b want %b", n, b2.data_req_o, cnt != 0); end
         if (cnt != 0) begin
            checks++; if ({b2.data_AUX_o, b2.data_ID_o} !== q[0]) begin errors++; $display("FAIL rnd2_head@%0d: got %h want %h", n, {b2.data_AUX_o, b2.data_ID_o}, q[0]); end
         end
         if (!holding && $urandom_range(0, 3) != 0) begin
            pend = {$urandom, $urandom, 20'($urandom)};
            holding = 1'b1;
         end
         b2.data_req_i = holding;
         {b2.data_AUX_i, b2.data_ID_i} = pend;
         b2.data_gnt_i = ($urandom_range(0, 9) < (((n / 125) % 2 == 1) ? 3 : 8));
         if (b2.data_gnt_i && cnt != 0) void'(q.pop_front());
         if (holding && cnt != 2) begin q.push_back(pend); holding = 1'b0; end
         step();
      end
      b2.data_req_i = 1'b0; b2.data_gnt_i = 1'b0;
   endtask

   task automatic test_random_d8();
      logic [83:0] q[$];
      logic [83:0] pend;
      logic        holding;
      int unsigned cnt;
      holding = 1'b0; pend = '0;
      for (int n = 0; n < 1000; n++) begin
         cnt = q.size();
         checks++; if (b8.count_o !== 4'(cnt)) begin errors++; $display("FAIL rnd8_count@%0d: got %0d want %0d", n, b8.count_o, cnt); end
         checks++; if (b8.data_gnt_o !== (cnt != 8)) begin errors++; $display("FAIL rnd8_gnt@%0d: got %b want %b", n, b8.data_gnt_o, cnt != 8); end
         checks++; if (b8.data_req_o !== (cnt != 0)) begin errors++; $display("FAIL rnd8_req@%0d: got %b want %b", n, b8.data_req_o, cnt != 0); end
         if (cnt != 0) begin
            checks++; if ({b8.data_AUX_o, b8.data_ID_o} !== q[0]) begin errors++; $display("FAIL rnd8_head@%0d: got %h want %h", n, {b8.data_AUX_o, b8.data_ID_o}, q[0]); end
         end
         if (!holding && $urandom_range(0, 3) != 0) begin
            pend = {$urandom, $urandom, 20'($urandom)};
            holding = 1'b1;
         end
         b8.data_req_i = holding;
         {b8.data_AUX_i, b8.data_ID_i} = pend;
         b8.data_gnt_i = ($urandom_range(0, 9) < (((n / 125) % 2 == 1) ? 2 : 8));
         if (b8.data_gnt_i && cnt != 0) void'(q.pop_front());
         if (holding && cnt != 8) begin q.push_back(pend); holding = 1'b0; end
         step();
      end
      b8.data_req_i = 1'b0; b8.data_gnt_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_pass();
      test_fill();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_random_d2();
      test_random_d8();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
